// File: rtl/mc_sequencer.sv
// -----------------------------------------------------------------------------
// mc_sequencer
//   Multi-cycle control FSM for the MiniSRC datapath. Fetches each instruction
//   over the shared memory port into an internal IR, decodes IR[31:27] and
//   walks the datapath through FETCH / DECODE / EXEC / MEM / WB1 / WB2 by
//   driving every enable and mux select. Outputs are a pure function of
//   (state, IR) plus the memory-ready and branch-flag inputs.
//
// Parameters
//   MEM_WAIT_MAX  cycles a memory access may go without iMemReady before the
//                 FSM gives up and enters FAULT (4-bit wait counter)
//
// Ports
//   iClk, iRst                       clock (rising edge), async active-high reset
//   iMemData, iMemReady              memory read data / access complete
//   oMemRead, oMemWrite              memory requests, held until iMemReady
//   iJ_zero/nZero/pos/neg            branch condition flags (RF port B value)
//   oPC_nRst/en/load/offset          PC controls (nRst low holds PC in reset)
//   oRF_Write, oRF_AddrA/B/C         register file strobe and addresses
//   oRWB_en .. oRAS_en               datapath register enables
//   oALU_Ctrl                        ALU operation select
//   oMUX_*                           datapath mux selects
//   oImm32                           sign-extended IR[18:0]
//   oHalted                          FSM in HALT or FAULT
//   iStep (CTRL_SSTEP_EN only)       single-step advance, rising-edge sensitive
//
// Configuration
//   CTRL_SSTEP_EN  when defined, each retiring instruction parks the FSM in
//                  PAUSE until a rising edge on iStep.
// -----------------------------------------------------------------------------
module mc_sequencer #(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
`ifdef CTRL_SSTEP_EN
   input  logic        iStep,
`endif
   input  logic        iClk,
   input  logic        iRst,
   input  logic [31:0] iMemData,
   input  logic        iMemReady,
   output logic        oMemRead,
   output logic        oMemWrite,
   input  logic        iJ_zero,
   input  logic        iJ_nZero,
   input  logic        iJ_pos,
   input  logic        iJ_neg,
   output logic        oPC_nRst,
   output logic        oPC_en,
   output logic        oPC_load,
   output logic        oPC_offset,
   output logic        oRF_Write,
   output logic [3:0]  oRF_AddrA,
   output logic [3:0]  oRF_AddrB,
   output logic [3:0]  oRF_AddrC,
   output logic        oRWB_en,
   output logic        oRA_en,
   output logic        oRB_en,
   output logic        oRZH_en,
   output logic        oRZL_en,
   output logic        oRAS_en,
   output logic [3:0]  oALU_Ctrl,
   output logic        oMUX_BIS,
   output logic        oMUX_RZHS,
   output logic        oMUX_WBM,
   output logic        oMUX_MAP,
   output logic        oMUX_ASS,
   output logic        oMUX_WBP,
   output logic [31:0] oImm32,
   output logic        oHalted
);

   typedef enum logic [3:0] {
      S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB1, S_WB2, S_HALT, S_FAULT, S_PAUSE
   } state_t;

   localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14;
   localparam logic [4:0] OP_DIV  = 5'd15, OP_MUL  = 5'd16, OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18, OP_BR   = 5'd19, OP_JR   = 5'd20;
   localparam logic [4:0] OP_JAL  = 5'd21, OP_MFHI = 5'd24, OP_MFLO = 5'd25;
   localparam logic [4:0] OP_NOP  = 5'd26, OP_HALT = 5'd27;
   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

   // Where a finished instruction goes next.
`ifdef CTRL_SSTEP_EN
   localparam state_t S_RETIRE = S_PAUSE;
`else
   localparam state_t S_RETIRE = S_FETCH;
`endif

   state_t      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   logic       is_alu_reg, is_imm, is_muldiv, is_mf, is_fault, br_taken;
   logic       mem_req, wait_cyc, timeout;
   logic [4:0] alu_diff;
   logic [3:0] alu_sel;

   assign op = ir_q[31:27];
   assign ra = ir_q[26:23];
   assign rb = ir_q[22:19];
   assign rc = ir_q[18:15];

   assign is_alu_reg = (op >= 5'd3 && op <= 5'd11) || op == OP_NEG || op == OP_NOT;
   assign is_imm     = op == OP_LD || op == OP_LDI || op == OP_ST ||
                       op == OP_ADDI || op == OP_ANDI || op == OP_ORI;
   assign is_muldiv  = op == OP_MUL || op == OP_DIV;
   assign is_mf      = op == OP_MFHI || op == OP_MFLO;
   assign is_fault   = op == 5'd22 || op == 5'd23 || op[4:2] == 3'b111;

   // C2 lives in the low two bits of the Rb field.
   always_comb begin
      case (ir_q[20:19])
         2'b00:   br_taken = iJ_zero;
         2'b01:   br_taken = iJ_nZero;
         2'b10:   br_taken = iJ_pos;
         default: br_taken = iJ_neg;
      endcase
   end

   // Register ALU ops 3..11 map linearly onto ALU codes 0..8.
   assign alu_diff = op - 5'd3;
   always_comb begin
      alu_sel = 4'd0;
      if (op >= 5'd3 && op <= 5'd11) alu_sel = alu_diff[3:0];
      else if (op == OP_ANDI)        alu_sel = 4'd2;
      else if (op == OP_ORI)         alu_sel = 4'd3;
      else if (op == OP_DIV)         alu_sel = 4'd9;
      else if (op == OP_MUL)         alu_sel = 4'd10;
      else if (op == OP_NEG)         alu_sel = 4'd11;
      else if (op == OP_NOT)         alu_sel = 4'd12;
   end

   // Wait counter: runs only on request cycles lacking iMemReady, so it is
   // back at zero whenever a new request starts. A ready arriving on the
   // last allowed cycle wins over the timeout.
   assign mem_req  = state_q == S_FETCH || state_q == S_MEM;
   assign wait_cyc = mem_req && !iMemReady;
   assign timeout  = wait_cyc && cnt_q == WAIT_LAST;
   assign cnt_d    = wait_cyc ? cnt_q + 4'd1 : 4'd0;

   assign oImm32 = {{13{ir_q[18]}}, ir_q[18:0]};

`ifdef CTRL_SSTEP_EN
   // Reset to 1 so a step line already high out of reset is not an edge.
   logic step_q;
   logic step_rise;
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) step_q <= 1'b1;
      else      step_q <= iStep;
   end
   assign step_rise = iStep && !step_q;
`endif

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= S_RST;
         ir_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      oMemRead   = 1'b0;
      oMemWrite  = 1'b0;
      oPC_nRst   = 1'b1;
      oPC_en     = 1'b0;
      oPC_load   = 1'b0;
      oPC_offset = 1'b0;
      oRF_Write  = 1'b0;
      oRF_AddrA  = 4'd0;
      oRF_AddrB  = 4'd0;
      oRF_AddrC  = 4'd0;
      oRWB_en    = 1'b0;
      oRA_en     = 1'b0;
      oRB_en     = 1'b0;
      oRZH_en    = 1'b0;
      oRZL_en    = 1'b0;
      oRAS_en    = 1'b0;
      oALU_Ctrl  = 4'd0;
      oMUX_BIS   = 1'b0;
      oMUX_RZHS  = 1'b0;
      oMUX_WBM   = 1'b0;
      oMUX_MAP   = 1'b0;
      oMUX_ASS   = 1'b0;
      oMUX_WBP   = 1'b0;
      oHalted    = 1'b0;

      case (state_q)
         S_RST: begin
            oPC_nRst = 1'b0;
            state_d  = S_FETCH;
         end
         S_FETCH: begin
            oMUX_MAP = 1'b1;
            oMemRead = 1'b1;
            if (iMemReady) begin
               ir_d    = iMemData;
               oPC_en  = 1'b1;
               state_d = S_DECODE;
            end else if (timeout) begin
               state_d = S_FAULT;
            end
         end
         S_DECODE: begin
            oRA_en  = 1'b1;
            oRB_en  = 1'b1;
            state_d = S_EXEC;
            if (is_alu_reg) begin
               oRF_AddrA = rb;
               oRF_AddrB = rc;
            end
            if (is_imm) oRF_AddrA = rb;
            if (op == OP_ST) oRF_AddrB = ra;
            if (is_muldiv) begin
               oRF_AddrA = ra;
               oRF_AddrB = rb;
            end
            if (op == OP_BR) begin
               oRF_AddrB  = ra;
               oPC_en     = br_taken;
               oPC_offset = br_taken;
               state_d    = S_RETIRE;
            end else if (op == OP_JR || op == OP_JAL) begin
               oRF_AddrA = ra;
               oPC_en    = 1'b1;
               oPC_load  = 1'b1;
               if (op == OP_JAL) begin
                  oRF_AddrC = ra;
                  state_d   = S_WB1;
               end else begin
                  state_d   = S_RETIRE;
               end
            end else if (is_mf) begin
               state_d = S_WB1;
            end else if (op == OP_NOP) begin
               state_d = S_RETIRE;
            end else if (op == OP_HALT) begin
               state_d = S_HALT;
            end else if (is_fault) begin
               state_d = S_FAULT;
            end
         end
         S_EXEC: begin
            oALU_Ctrl = alu_sel;
            oMUX_BIS  = is_imm;
            if (is_muldiv) begin
               // HI/LO pair lands in RAS; nothing to write back.
               oRAS_en = 1'b1;
               state_d = S_RETIRE;
            end else begin
               oRZL_en = 1'b1;
               oRZH_en = 1'b1;
               state_d = (op == OP_LD || op == OP_ST) ? S_MEM : S_WB1;
            end
         end
         S_MEM: begin
            // Address comes from RZL: MAP/ASS/RZHS stay at 0.
            oMUX_BIS  = is_imm;
            oMemRead  = op == OP_LD;
            oMemWrite = op == OP_ST;
            if (iMemReady) state_d = (op == OP_LD) ? S_WB1 : S_RETIRE;
            else if (timeout) state_d = S_FAULT;
         end
         S_WB1, S_WB2: begin
            // Mux selects held steady across both writeback cycles.
            oRF_AddrC = ra;
            oMUX_WBM  = op == OP_LD;
            oMUX_WBP  = op == OP_JAL;
            oMUX_ASS  = is_mf;
            oMUX_RZHS = op == OP_MFHI;
            if (state_q == S_WB1) begin
               oRWB_en = 1'b1;
               state_d = S_WB2;
            end else begin
               oRF_Write = 1'b1;
               state_d   = S_RETIRE;
            end
         end
         S_HALT, S_FAULT: begin
            oHalted = 1'b1;
         end
`ifdef CTRL_SSTEP_EN
         S_PAUSE: begin
            if (step_rise) state_d = S_FETCH;
         end
`endif
         default: begin
            state_d = S_FAULT;
         end
      endcase
   end

endmodule

// File: tb/tb_mc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mc_sequencer
//   Directed bench for mc_sequencer. Inputs are driven and outputs sampled on
//   the falling clock edge; each instruction is walked state by state with
//   hand-computed expected control values.
// -----------------------------------------------------------------------------
module tb_mc_sequencer;

   logic        iClk = 1'b0;
   logic        iRst = 1'b1;
   logic [31:0] iMemData = '0;
   logic        iMemReady = 1'b1;
   logic        iJ_zero = 1'b0, iJ_nZero = 1'b0, iJ_pos = 1'b0, iJ_neg = 1'b0;
   logic        oMemRead, oMemWrite;
   logic        oPC_nRst, oPC_en, oPC_load, oPC_offset, oRF_Write;
   logic [3:0]  oRF_AddrA, oRF_AddrB, oRF_AddrC, oALU_Ctrl;
   logic        oRWB_en, oRA_en, oRB_en, oRZH_en, oRZL_en, oRAS_en;
   logic        oMUX_BIS, oMUX_RZHS, oMUX_WBM, oMUX_MAP, oMUX_ASS, oMUX_WBP;
   logic [31:0] oImm32;
   logic        oHalted;

   int checks = 0;
   int errors = 0;

   mc_sequencer #(.MEM_WAIT_MAX(15)) dut (
      .iClk(iClk), .iRst(iRst), .iMemData(iMemData), .iMemReady(iMemReady),
      .oMemRead(oMemRead), .oMemWrite(oMemWrite),
      .iJ_zero(iJ_zero), .iJ_nZero(iJ_nZero), .iJ_pos(iJ_pos), .iJ_neg(iJ_neg),
      .oPC_nRst(oPC_nRst), .oPC_en(oPC_en), .oPC_load(oPC_load), .oPC_offset(oPC_offset),
      .oRF_Write(oRF_Write), .oRF_AddrA(oRF_AddrA), .oRF_AddrB(oRF_AddrB), .oRF_AddrC(oRF_AddrC),
      .oRWB_en(oRWB_en), .oRA_en(oRA_en), .oRB_en(oRB_en), .oRZH_en(oRZH_en),
      .oRZL_en(oRZL_en), .oRAS_en(oRAS_en), .oALU_Ctrl(oALU_Ctrl),
      .oMUX_BIS(oMUX_BIS), .oMUX_RZHS(oMUX_RZHS), .oMUX_WBM(oMUX_WBM),
      .oMUX_MAP(oMUX_MAP), .oMUX_ASS(oMUX_ASS), .oMUX_WBP(oMUX_WBP),
      .oImm32(oImm32), .oHalted(oHalted)
   );

   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge iClk);
   endtask

   function automatic logic [31:0] ins(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [18:0] imm);
      return {op, ra, rb, imm};
   endfunction

   // Called in a FETCH cycle: present the word with zero wait, step to DECODE.
   task automatic fetch(input string name, input logic [31:0] word);
      $display("txn %s ir=%h", name, word);
      iMemData  = word;
      iMemReady = 1'b1;
      check({name, "_fetch_rd"}, 32'(oMemRead), 32'd1);
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      // ---- reset and addi R2,R0,5 ----
      iMemData = ins(5'd12, 4'd2, 4'd0, 19'd5);
      cyc(); cyc();
      check("rst_pc_nrst", 32'(oPC_nRst), 32'd0);
      check("rst_memrd",   32'(oMemRead), 32'd0);
      check("rst_halted",  32'(oHalted),  32'd0);
      iRst = 1'b0;
      cyc();
      check("addi_map",    32'(oMUX_MAP), 32'd1);
      check("addi_pc_en",  32'(oPC_en),   32'd1);
      fetch("addi", ins(5'd12, 4'd2, 4'd0, 19'd5));
      check("addi_ra_en",  32'(oRA_en),    32'd1);
      check("addi_addra",  32'(oRF_AddrA), 32'd0);
      check("addi_pc_nrst",32'(oPC_nRst),  32'd1);
      cyc();
      check("addi_alu",    32'(oALU_Ctrl), 32'd0);
      check("addi_bis",    32'(oMUX_BIS),  32'd1);
      check("addi_rzl",    32'(oRZL_en),   32'd1);
      check("addi_imm",    oImm32,         32'd5);
      cyc();
      check("addi_rwb",    32'(oRWB_en),   32'd1);
      check("addi_wb1_wr", 32'(oRF_Write), 32'd0);
      cyc();
      check("addi_write",  32'(oRF_Write), 32'd1);
      check("addi_addrc",  32'(oRF_AddrC), 32'd2);
      cyc();

      // ---- add R5,R3,R4 ----
      fetch("add", ins(5'd3, 4'd5, 4'd3, {4'd4, 15'd0}));
      check("add_addra",   32'(oRF_AddrA), 32'd3);
      check("add_addrb",   32'(oRF_AddrB), 32'd4);
      cyc();
      check("add_alu",     32'(oALU_Ctrl), 32'd0);
      check("add_bis",     32'(oMUX_BIS),  32'd0);
      cyc(); cyc();
      check("add_write",   32'(oRF_Write), 32'd1);
      check("add_addrc",   32'(oRF_AddrC), 32'd5);
      cyc();

      // ---- ror R1,R2,R3 ----
      fetch("ror", ins(5'd7, 4'd1, 4'd2, {4'd3, 15'd0}));
      cyc();
      check("ror_alu",     32'(oALU_Ctrl), 32'd4);
      cyc(); cyc(); cyc();

      // ---- brzr R1,+3 taken ----
      iJ_zero = 1'b1;
      fetch("brzr_t", ins(5'd19, 4'd1, 4'b0000, 19'd3));
      check("brzr_t_pcen", 32'(oPC_en),     32'd1);
      check("brzr_t_off",  32'(oPC_offset), 32'd1);
      check("brzr_t_addrb",32'(oRF_AddrB),  32'd1);
      check("brzr_t_imm",  oImm32,          32'd3);
      cyc();
      check("brzr_t_next", 32'(oMemRead),   32'd1);

      // ---- brzr R1,+3 not taken ----
      iJ_zero = 1'b0; iJ_nZero = 1'b1;
      fetch("brzr_n", ins(5'd19, 4'd1, 4'b0000, 19'd3));
      check("brzr_n_pcen", 32'(oPC_en),     32'd0);
      check("brzr_n_off",  32'(oPC_offset), 32'd0);
      cyc();
      check("brzr_n_next", 32'(oMemRead),   32'd1);

      // ---- brmi R2,-2 taken (sign extension) ----
      iJ_nZero = 1'b0; iJ_neg = 1'b1;
      fetch("brmi", ins(5'd19, 4'd2, 4'b0011, 19'h7FFFE));
      check("brmi_off",    32'(oPC_offset), 32'd1);
      check("brmi_imm",    oImm32,          32'hFFFF_FFFE);
      iJ_neg = 1'b0;
      cyc();

      // ---- mul R6,R7 ----
      fetch("mul", ins(5'd16, 4'd6, 4'd7, 19'd0));
      check("mul_addra",   32'(oRF_AddrA), 32'd6);
      check("mul_addrb",   32'(oRF_AddrB), 32'd7);
      cyc();
      check("mul_ras",     32'(oRAS_en),   32'd1);
      check("mul_rzl",     32'(oRZL_en),   32'd0);
      check("mul_alu",     32'(oALU_Ctrl), 32'd10);
      cyc();
      check("mul_nowrite", 32'(oRF_Write), 32'd0);
      check("mul_next",    32'(oMemRead),  32'd1);

      // ---- mfhi R8 ----
      fetch("mfhi", ins(5'd24, 4'd8, 4'd0, 19'd0));
      cyc();
      check("mfhi_rwb",    32'(oRWB_en),   32'd1);
      check("mfhi_ass",    32'(oMUX_ASS),  32'd1);
      check("mfhi_rzhs",   32'(oMUX_RZHS), 32'd1);
      check("mfhi_addrc",  32'(oRF_AddrC), 32'd8);
      cyc();
      check("mfhi_write",  32'(oRF_Write), 32'd1);
      cyc();

      // ---- jal R4 ----
      fetch("jal", ins(5'd21, 4'd4, 4'd0, 19'd0));
      check("jal_load",    32'(oPC_load),  32'd1);
      check("jal_addra",   32'(oRF_AddrA), 32'd4);
      cyc();
      check("jal_wbp",     32'(oMUX_WBP),  32'd1);
      check("jal_addrc",   32'(oRF_AddrC), 32'd4);
      cyc();
      check("jal_write",   32'(oRF_Write), 32'd1);
      cyc();

      // ---- ld R1,8(R2), ready withheld 15 cycles -> FAULT ----
      fetch("ld_to", ins(5'd0, 4'd1, 4'd2, 19'd8));
      check("ld_to_addra", 32'(oRF_AddrA), 32'd2);
      cyc();
      check("ld_to_bis",   32'(oMUX_BIS),  32'd1);
      iMemReady = 1'b0;
      cyc();
      check("ld_to_map",   32'(oMUX_MAP),  32'd0);
      for (int i = 0; i < 14; i++) cyc();
      check("ld_to_c15",   32'(oMemRead),  32'd1);
      cyc();
      check("ld_to_halt",  32'(oHalted),   32'd1);
      check("ld_to_rd",    32'(oMemRead),  32'd0);
      cyc();
      check("ld_to_hold",  32'(oHalted),   32'd1);

      // ---- reset, ld with ready on 15th wait cycle -> writeback ----
      iRst = 1'b1;
      cyc();
      iRst = 1'b0; iMemReady = 1'b1;
      cyc();
      fetch("ld_ok", ins(5'd0, 4'd1, 4'd2, 19'd8));
      cyc();
      iMemReady = 1'b0;
      cyc();
      for (int i = 0; i < 13; i++) cyc();
      cyc();
      iMemReady = 1'b1;
      check("ld_ok_c15",   32'(oMemRead),  32'd1);
      cyc();
      check("ld_ok_halt",  32'(oHalted),   32'd0);
      check("ld_ok_rwb",   32'(oRWB_en),   32'd1);
      check("ld_ok_wbm",   32'(oMUX_WBM),  32'd1);
      cyc();
      check("ld_ok_write", 32'(oRF_Write), 32'd1);
      cyc();

      // ---- st R3,4(R0) with reset during MEM ----
      fetch("st", ins(5'd2, 4'd3, 4'd0, 19'd4));
      check("st_addrb",    32'(oRF_AddrB), 32'd3);
      cyc();
      iMemReady = 1'b0;
      cyc();
      check("st_memwr",    32'(oMemWrite), 32'd1);
      #2 iRst = 1'b1;
      #1;
      check("st_rst_wr",   32'(oMemWrite), 32'd0);
      check("st_rst_pc",   32'(oPC_nRst),  32'd0);
      cyc();
      iRst = 1'b0; iMemReady = 1'b1;
      cyc();
      check("st_refetch",  32'(oMUX_MAP),  32'd1);

      // ---- nop, then halt ----
      fetch("nop", ins(5'd26, 4'd0, 4'd0, 19'd0));
      cyc();
      check("nop_next",    32'(oMemRead),  32'd1);
      fetch("halt", ins(5'd27, 4'd0, 4'd0, 19'd0));
      cyc();
      check("halt_halted", 32'(oHalted),   32'd1);
      cyc();
      check("halt_hold_rd",32'(oMemRead),  32'd0);
      check("halt_hold",   32'(oHalted),   32'd1);

      // ---- illegal opcode 11100 -> FAULT ----
      iRst = 1'b1;
      cyc();
      iRst = 1'b0;
      cyc();
      fetch("ill", ins(5'd28, 4'd0, 4'd0, 19'd0));
      cyc();
      check("ill_halted",  32'(oHalted),   32'd1);
      check("ill_rwb",     32'(oRWB_en),   32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
